// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with registered read data, read-valid,
// selectable own-write output behaviour, optional output stage and
// cross-port collision flags. One shared clock, one access per port per cycle.
module dual_port_ram_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int WR_MODE = 0,  // 0 no-change, 1 write-first, 2 read-first
  parameter int OUT_REG = 0   // 1 adds a second output register stage
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] out1,
  output logic              valid1,
  input  logic              en2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] adr2,
  input  logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] out2,
  output logic              valid2,
  output logic [1:0]        coll
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NP    = 2;

  // Storage is never reset; contents survive rst.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Port signals gathered into packed arrays so the per-port logic is one loop.
  logic [NP-1:0]             en_w, we_w, vout_w;
  logic [NP-1:0][ADDR_W-1:0] adr_w;
  logic [NP-1:0][DATA_W-1:0] din_w, rdo_w, dout_w;

  assign en_w  = {en2, en1};
  assign we_w  = {we2, we1};
  assign adr_w = {adr2, adr1};
  assign din_w = {data2, data1};

  // Array read happens before the edge updates it, so every read (including
  // a read-first own write and a cross-port read/write) returns old data.
  assign rdo_w[0] = mem_q[adr1];
  assign rdo_w[1] = mem_q[adr2];

  // Memory write: port 2 first, port 1 last so port 1 wins a same-address
  // write/write. Accesses presented while rst is high are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (en2 && we2) mem_q[adr2] <= data2;
      if (en1 && we1) mem_q[adr1] <= data1;
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_port
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              vld_q, vld_d;

    // First output stage next-state: read, own-write mode, or idle hold.
    always_comb begin
      dat_d = dat_q;
      vld_d = 1'b0;
      if (en_w[g]) begin
        if (we_w[g]) begin
          if (WR_MODE == 1) begin
            dat_d = din_w[g];
            vld_d = 1'b1;
          end else if (WR_MODE == 2) begin
            dat_d = rdo_w[g];
            vld_d = 1'b1;
          end else begin
            vld_d = vld_q;  // no-change: data and valid both untouched
          end
        end else begin
          dat_d = rdo_w[g];
          vld_d = 1'b1;
        end
      end
    end

    // First output stage register.
    always_ff @(posedge clk) begin
      if (rst) begin
        dat_q <= '0;
        vld_q <= 1'b0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] dat2_q;
      logic              vld2_q;

      // Extra stage copies stage 1 every cycle, so hold behaviour carries through.
      always_ff @(posedge clk) begin
        if (rst) begin
          dat2_q <= '0;
          vld2_q <= 1'b0;
        end else begin
          dat2_q <= dat_q;
          vld2_q <= vld_q;
        end
      end

      assign dout_w[g] = dat2_q;
      assign vout_w[g] = vld2_q;
    end else begin : g_noreg
      assign dout_w[g] = dat_q;
      assign vout_w[g] = vld_q;
    end
  end

  assign out1   = dout_w[0];
  assign out2   = dout_w[1];
  assign valid1 = vout_w[0];
  assign valid2 = vout_w[1];

  // Collision detect: [0] both write, [1] one reads while the other writes.
  logic       same_adr, both_en;
  logic [1:0] coll_d, coll_q;

  assign same_adr = (adr1 == adr2);
  assign both_en  = en1 & en2 & same_adr;
  assign coll_d   = {both_en & (we1 ^ we2), both_en & we1 & we2};

  // Collision flags pipelined to line up with the read data.
  always_ff @(posedge clk) begin
    if (rst) coll_q <= 2'b00;
    else     coll_q <= coll_d;
  end

  if (OUT_REG != 0) begin : g_coll_oreg
    logic [1:0] coll2_q;

    // Second collision stage matching the extra data stage.
    always_ff @(posedge clk) begin
      if (rst) coll2_q <= 2'b00;
      else     coll2_q <= coll_q;
    end

    assign coll = coll2_q;
  end else begin : g_coll_noreg
    assign coll = coll_q;
  end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Self-checking bench: three 8-bit latency-1 instances (WR_MODE 0/1/2) and one
// 16-bit latency-2 instance share one stimulus stream and are compared against
// a behavioural memory model every cycle, plus directed literal checks.
module tb_dual_port_ram_param;

  logic        clk = 1'b0;
  logic        rst, en1, we1, en2, we2;
  logic [5:0]  adr1, adr2;
  logic [15:0] data1, data2;

  logic [7:0]  o1 [3];
  logic [7:0]  o2 [3];
  logic        v1 [3];
  logic        v2 [3];
  logic [1:0]  c  [3];
  logic [15:0] w1, w2;
  logic        wv1, wv2;
  logic [1:0]  wc;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_m
    dual_port_ram_param #(.DATA_W(8), .ADDR_W(6), .WR_MODE(m), .OUT_REG(0)) u_dut (
      .clk(clk), .rst(rst),
      .en1(en1), .we1(we1), .adr1(adr1), .data1(data1[7:0]), .out1(o1[m]), .valid1(v1[m]),
      .en2(en2), .we2(we2), .adr2(adr2), .data2(data2[7:0]), .out2(o2[m]), .valid2(v2[m]),
      .coll(c[m])
    );
  end

  dual_port_ram_param #(.DATA_W(16), .ADDR_W(6), .WR_MODE(0), .OUT_REG(1)) u_wide (
    .clk(clk), .rst(rst),
    .en1(en1), .we1(we1), .adr1(adr1), .data1(data1), .out1(w1), .valid1(wv1),
    .en2(en2), .we2(we2), .adr2(adr2), .data2(data2), .out2(w2), .valid2(wv2),
    .coll(wc)
  );

  // Reference model: memory plus what each instance shows after one edge
  // (s1_*) and at its output pins (fo/fv/fc). Instance 3 is the 16-bit
  // no-change instance whose pins show the one-edge result a cycle late.
  logic [15:0] mmem   [64];
  logic [15:0] s1_out [4][2];
  logic        s1_vld [4][2];
  logic [15:0] fo     [4][2];
  logic        fv     [4][2];
  logic [1:0]  s1c, fc3;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_update();
    logic        e [2], w [2];
    logic [5:0]  a [2];
    logic [15:0] d [2];
    e[0] = en1; w[0] = we1; a[0] = adr1; d[0] = data1;
    e[1] = en2; w[1] = we2; a[1] = adr2; d[1] = data2;
    if (rst) begin
      for (int m = 0; m < 4; m++)
        for (int p = 0; p < 2; p++) begin
          s1_out[m][p] = '0; s1_vld[m][p] = 1'b0; fo[m][p] = '0; fv[m][p] = 1'b0;
        end
      s1c = 2'b00; fc3 = 2'b00;
    end else begin
      // Wide instance: pins take last cycle's one-edge result.
      for (int p = 0; p < 2; p++) begin
        fo[3][p] = s1_out[3][p];
        fv[3][p] = s1_vld[3][p];
      end
      fc3 = s1c;
      s1c = 2'b00;
      if (en1 && en2 && adr1 == adr2) begin
        if (we1 && we2) s1c = 2'b01;
        else if (we1 != we2) s1c = 2'b10;
      end
      for (int m = 0; m < 4; m++) begin
        int mode;
        mode = (m == 3) ? 0 : m;
        for (int p = 0; p < 2; p++) begin
          if (!e[p]) s1_vld[m][p] = 1'b0;
          else if (!w[p]) begin
            s1_out[m][p] = mmem[a[p]]; s1_vld[m][p] = 1'b1;
          end else if (mode == 1) begin
            s1_out[m][p] = d[p]; s1_vld[m][p] = 1'b1;
          end else if (mode == 2) begin
            s1_out[m][p] = mmem[a[p]]; s1_vld[m][p] = 1'b1;
          end
        end
      end
      for (int m = 0; m < 3; m++)
        for (int p = 0; p < 2; p++) begin
          fo[m][p] = s1_out[m][p] & 16'h00FF;
          fv[m][p] = s1_vld[m][p];
        end
      // Port 1 applied last: it wins a same-address double write.
      if (en2 && we2) mmem[adr2] = data2;
      if (en1 && we1) mmem[adr1] = data1;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("m%0d.out1", m), {8'h00, o1[m]}, fo[m][0]);
      chk($sformatf("m%0d.out2", m), {8'h00, o2[m]}, fo[m][1]);
      chk($sformatf("m%0d.valid1", m), {15'd0, v1[m]}, {15'd0, fv[m][0]});
      chk($sformatf("m%0d.valid2", m), {15'd0, v2[m]}, {15'd0, fv[m][1]});
      chk($sformatf("m%0d.coll", m), {14'd0, c[m]}, {14'd0, s1c});
    end
    chk("wide.out1", w1, fo[3][0]);
    chk("wide.out2", w2, fo[3][1]);
    chk("wide.valid1", {15'd0, wv1}, {15'd0, fv[3][0]});
    chk("wide.valid2", {15'd0, wv2}, {15'd0, fv[3][1]});
    chk("wide.coll", {14'd0, wc}, {14'd0, fc3});
  endtask

  task automatic step(input logic r,
                      input logic e1, input logic x1, input logic [5:0] a1, input logic [15:0] d1,
                      input logic e2, input logic x2, input logic [5:0] a2, input logic [15:0] d2);
    rst = r; en1 = e1; we1 = x1; adr1 = a1; data1 = d1;
    en2 = e2; we2 = x2; adr2 = a2; data2 = d2;
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_step(input logic r);
    logic [5:0] a1, a2;
    a1 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
    a2 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
    step(r, 1'($urandom), 1'($urandom), a1, 16'($urandom),
            1'($urandom), 1'($urandom), a2, 16'($urandom));
  endtask

  initial begin
    // Reset from power-up with idle ports.
    step(1'b1, 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0);
    step(1'b1, 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0);
    chk("reset.out1", {8'h00, o1[0]}, 16'h0000);
    chk("reset.wide.valid1", {15'd0, wv1}, 16'h0000);

    // Fill memory with known random words so every read has a defined value.
    for (int i = 0; i < 32; i++)
      step(1'b0, 1, 1, 6'(2 * i), 16'($urandom), 1, 1, 6'(2 * i + 1), 16'($urandom));

    // Random traffic with frequent same-address pairs.
    for (int i = 0; i < 200; i++) rand_step(1'b0);

    // Reset for 2 cycles with random accesses presented: they must be dropped.
    rand_step(1'b1);
    rand_step(1'b1);
    chk("rst.out2", {8'h00, o2[2]}, 16'h0000);
    chk("rst.coll", {14'd0, c[1]}, 16'h0000);
    // Memory retained: read back both ports across the array.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1, 0, 6'(i * 8), 16'h0, 1, 0, 6'(i * 8 + 3), 16'h0);

    // Basic writes and reads.
    step(1'b0, 1, 1, 6'd0, 16'd12, 1, 1, 6'd1, 16'd14);
    step(1'b0, 1, 1, 6'd2, 16'd22, 1, 1, 6'd3, 16'd24);
    step(1'b0, 1, 0, 6'd2, 16'h0,  1, 0, 6'd3, 16'h0);
    chk("basic.rd2", {8'h00, o1[0]}, 16'd22);
    chk("basic.rd3", {8'h00, o2[0]}, 16'd24);
    step(1'b0, 1, 0, 6'd0, 16'h0,  1, 0, 6'd1, 16'h0);
    chk("basic.rd0", {8'h00, o1[0]}, 16'd12);
    chk("basic.rd1", {8'h00, o2[0]}, 16'd14);
    chk("basic.wide.rd2", w1, 16'd22);
    chk("basic.wide.rd3", w2, 16'd24);
    step(1'b0, 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0);
    chk("basic.wide.rd0", w1, 16'd12);
    chk("basic.wide.rd1", w2, 16'd14);
    chk("idle.valid1", {15'd0, v1[0]}, 16'h0000);

    // Write/write collision: port 1 data wins.
    step(1'b0, 1, 1, 6'd5, 16'h00AA, 1, 1, 6'd5, 16'h0055);
    chk("ww.coll", {14'd0, c[0]}, 16'h0001);
    step(1'b0, 1, 0, 6'd5, 16'h0, 0, 0, 6'd0, 16'h0);
    chk("ww.rd5", {8'h00, o1[0]}, 16'h00AA);
    chk("ww.coll.pulse", {14'd0, c[0]}, 16'h0000);
    chk("ww.wide.coll", {14'd0, wc}, 16'h0001);

    // Read/write collision: reader sees old data.
    step(1'b0, 1, 1, 6'd7, 16'h0011, 0, 0, 6'd0, 16'h0);
    step(1'b0, 1, 1, 6'd7, 16'h0022, 1, 0, 6'd7, 16'h0);
    chk("rw.old", {8'h00, o2[0]}, 16'h0011);
    chk("rw.coll", {14'd0, c[0]}, 16'h0002);
    step(1'b0, 0, 0, 6'd0, 16'h0, 1, 0, 6'd7, 16'h0);
    chk("rw.new", {8'h00, o2[0]}, 16'h0022);

    // Own-write output mode sweep.
    step(1'b0, 1, 0, 6'd3, 16'h0, 0, 0, 6'd0, 16'h0);
    step(1'b0, 1, 1, 6'd9, 16'h0001, 0, 0, 6'd0, 16'h0);
    step(1'b0, 1, 1, 6'd9, 16'h0002, 0, 0, 6'd0, 16'h0);
    chk("mode0.hold", {8'h00, o1[0]}, 16'd24);
    chk("mode1.new",  {8'h00, o1[1]}, 16'h0002);
    chk("mode2.old",  {8'h00, o1[2]}, 16'h0001);

    // Back-to-back reads of the whole array on both ports.
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1, 0, 6'(i), 16'h0, 1, 0, 6'(63 - i), 16'h0);
      if (i >= 1) begin
        chk("sweep.wide.valid1", {15'd0, wv1}, 16'h0001);
        chk("sweep.wide.valid2", {15'd0, wv2}, 16'h0001);
      end
    end
    step(1'b0, 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0);
    chk("sweep.tail", w1, mmem[63]);
    step(1'b0, 0, 0, 6'd0, 16'h0, 0, 0, 6'd0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
